// File: rtl/halflife_pkg.sv
// halflife_pkg: shared state encoding, default sizes and drain arithmetic for the decay sequencer.
package halflife_pkg;

    localparam int N_DEF         = 4;
    localparam int HALF_LIFE_DEF = 16;
    localparam int H_DEF         = 3;

    typedef enum logic [2:0] {IDLE, LOAD, WAIT, DRAIN, DONE} state_e;

    // Decrements needed to halve q, rounding the remaining count down.
    function automatic int unsigned half_drain(input int unsigned q);
        return q - (q >> 1);
    endfunction

endpackage

// File: rtl/halflife_period_timer.sv
// halflife_period_timer: mod-HALF_LIFE counter with synchronous clear and a boundary flag on the last count.
module halflife_period_timer #(
    parameter int HALF_LIFE = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    output logic bnd_o
);

    localparam int TW = $clog2(HALF_LIFE);

    logic [TW-1:0] t_q, t_d;

    assign bnd_o = t_q == TW'(HALF_LIFE - 1);

    always_comb t_d = (clr_i || bnd_o) ? '0 : t_q + TW'(1);

    always_ff @(posedge clk)
        t_q <= rst ? '0 : t_d;

endmodule

// File: rtl/halflife_decay_seq.sv
// halflife_decay_seq: drives a load/up/down counter so its value halves once per half-life
// period, issuing one down strobe per cycle until the count reaches 0.
module halflife_decay_seq
    import halflife_pkg::*;
#(
    parameter int N         = N_DEF,
    parameter int HALF_LIFE = HALF_LIFE_DEF,
    parameter int H         = H_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [N-1:0] init_val,
    input  logic [N-1:0] cnt_q,
    output logic         cnt_load,
    output logic [N-1:0] cnt_in,
    output logic         cnt_up,
    output logic         cnt_down,
    output logic         busy,
    output logic         done,
    output logic [H-1:0] halvings
);

    state_e       state_q, state_d;
    logic [N-1:0] drain_q, drain_d, cnt_in_q, cnt_in_d;
    logic [H-1:0] halv_q, halv_d;
    logic         last_q, last_d, load_q, load_d, down_q, down_d;
    logic         busy_q, busy_d, done_q, done_d;
    logic         bnd, sample;

    halflife_period_timer #(.HALF_LIFE(HALF_LIFE)) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clr_i(state_q == LOAD),
        .bnd_o(bnd)
    );

    assign sample = state_q == WAIT && bnd;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            drain_q  <= '0;
            last_q   <= 1'b0;
            halv_q   <= '0;
            load_q   <= 1'b0;
            down_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_in_q <= '0;
        end else begin
            state_q  <= state_d;
            drain_q  <= drain_d;
            last_q   <= last_d;
            halv_q   <= halv_d;
            load_q   <= load_d;
            down_q   <= down_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            cnt_in_q <= cnt_in_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start && !abort) state_d = (init_val != '0) ? LOAD : DONE;
            LOAD:    state_d = WAIT;
            WAIT:    if (bnd) state_d = (half_drain(32'(cnt_q)) != 0) ? DRAIN : DONE;
            DRAIN:   if (drain_q == N'(1)) state_d = last_q ? DONE : WAIT;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (abort && state_q inside {LOAD, WAIT, DRAIN}) state_d = IDLE;
    end

    // Outputs are computed from the next state so each strobe lines up with its state.
    always_comb begin
        load_d   = state_d == LOAD;
        down_d   = state_d == DRAIN;
        busy_d   = state_d inside {LOAD, WAIT, DRAIN};
        done_d   = state_d == DONE;
        cnt_in_d = (state_d == LOAD) ? init_val : '0;
        drain_d  = sample ? N'(half_drain(32'(cnt_q))) : (state_q == DRAIN) ? drain_q - N'(1) : drain_q;
        last_d   = sample ? cnt_q <= N'(1) : last_q;
        halv_d   = (state_q == IDLE && state_d == LOAD) ? '0 :
                   (sample && !abort && !(&halv_q)) ? halv_q + H'(1) : halv_q;
    end

    // An abort cancels the strobe of its own cycle, leaving the counter untouched.
    assign cnt_load = load_q && !abort;
    assign cnt_down = down_q && !abort;
    assign cnt_in   = cnt_in_q;
    assign cnt_up   = 1'b0;
    assign busy     = busy_q;
    assign done     = done_q;
    assign halvings = halv_q;

endmodule

// File: tb/tb_halflife_decay_seq.sv
// tb_halflife_decay_seq: closes the loop with a counter model and compares every cycle against
// a run-level reference built from the half-life rules.
module tb_halflife_decay_seq;

    localparam int L = 80;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0;
    logic [3:0] init_val = '0, cnt_q, cnt_in;
    logic       cnt_load, cnt_up, cnt_down, busy, done;
    logic [2:0] halvings;

    logic [8:0] ev [L];
    logic [8:0] ev_a [L];
    int exp_q = 0, exp_h = 0;
    int n_chk = 0, n_pass = 0;

    halflife_decay_seq dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .init_val(init_val),
        .cnt_q(cnt_q), .cnt_load(cnt_load), .cnt_in(cnt_in), .cnt_up(cnt_up),
        .cnt_down(cnt_down), .busy(busy), .done(done), .halvings(halvings)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk)
        if (rst) cnt_q <= '0;
        else if (cnt_load) cnt_q <= cnt_in;
        else if (cnt_up) cnt_q <= cnt_q + 4'd1;
        else if (cnt_down) cnt_q <= cnt_q - 4'd1;

    function automatic logic [8:0] obs();
        return {cnt_up, cnt_load, cnt_down, busy, done, cnt_in};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Per-cycle expectation {up,load,down,busy,done,in}: start in cycle 0, load in cycle 1,
    // boundaries every 16 cycles from cycle 17, each halving drained one step per cycle.
    task automatic build(input int init, input int a);
        int q, t, d, dc, h, lim;
        bit lst;
        bit bd [L];
        for (int c = 0; c < L; c++) begin
            ev[c] = '0;
            bd[c] = 1'b0;
        end
        if (a == 0) return;
        dc = 1;
        if (init != 0) begin
            ev[1][7] = 1'b1;
            ev[1][3:0] = 4'(init);
            q = init;
            t = 17;
            while (1) begin
                bd[t] = 1'b1;
                d = q - q / 2;
                lst = q <= 1;
                if (d == 0) begin
                    dc = t + 1;
                    break;
                end
                for (int i = 1; i <= d; i++) ev[t+i][6] = 1'b1;
                q -= d;
                if (lst) begin
                    dc = t + d + 1;
                    break;
                end
                t += 16;
            end
            for (int c = 1; c < dc; c++) ev[c][5] = 1'b1;
        end
        ev[dc][4] = 1'b1;
        lim = L;
        if (a > 0 && a < dc) begin
            lim = a;
            ev[a][7] = 1'b0;
            ev[a][6] = 1'b0;
            for (int c = a + 1; c < L; c++) ev[c] = '0;
        end
        if (init != 0) begin
            h = 0;
            for (int c = 0; c < lim; c++) if (bd[c]) h = (h < 7) ? h + 1 : 7;
            exp_h = h;
        end
        q = exp_q;
        for (int c = 0; c < L; c++)
            if (ev[c][7]) q = init;
            else if (ev[c][6]) q = q - 1;
        exp_q = q & 15;
    endtask

    task automatic run(input int init, input int a, input int s);
        build(init, a);
        for (int c = 0; c < L; c++) begin
            start = (c == 0) || (c == s);
            abort = c == a;
            init_val = (c == s) ? ~4'(init) : 4'(init);
            @(negedge clk);
            check($sformatf("outs i%0d a%0d s%0d c%0d", init, a, s, c), 32'(obs()), 32'(ev[c]));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        abort = 1'b0;
        check($sformatf("halvings i%0d", init), 32'(halvings), 32'(exp_h));
        check($sformatf("cnt_q i%0d", init), 32'(cnt_q), 32'(exp_q));
    endtask

    initial begin
        int init, a, s;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset outs", 32'(obs()), 32'd0);
        check("reset halvings", 32'(halvings), 32'd0);
        @(posedge clk);
        #1;
        run(12, -1, -1);
        run(0, -1, -1);
        run(15, -1, -1);
        run(12, 20, -1);
        run(12, -1, 30);
        run(1, -1, -1);
        run(2, 1, -1);
        run(9, 17, -1);
        for (int k = 0; k < 20; k++) begin
            init = $urandom_range(0, 15);
            a = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 70) : -1;
            s = (init != 0 && $urandom_range(0, 1) == 1) ? $urandom_range(2, 16) : -1;
            if (s >= 0 && a >= 0 && a <= s) s = -1;
            run(init, a, s);
        end
        // Synchronous reset mid-run, then a fresh run two cycles later.
        build(12, -1);
        for (int c = 0; c < L; c++) ev_a[c] = ev[c];
        exp_q = 0;
        exp_h = 0;
        build(9, -1);
        for (int c = 0; c < 42 + L; c++) begin
            start = (c == 0) || (c == 42);
            rst = c == 40;
            init_val = (c >= 42) ? 4'd9 : 4'd12;
            @(negedge clk);
            check($sformatf("rst outs c%0d", c), 32'(obs()),
                  32'((c <= 40) ? ev_a[c] : (c == 41) ? 9'd0 : ev[c-42]));
            if (c == 41) check("rst halvings", 32'(halvings), 32'd0);
            @(posedge clk);
            #1;
        end
        start = 1'b0;
        rst = 1'b0;
        check("rst run halvings", 32'(halvings), 32'(exp_h));
        check("rst run cnt_q", 32'(cnt_q), 32'(exp_q));
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
